// File: rtl/branch_predict_unit.sv
// ==========================================================================
// branch_predict_unit : 2-bit BHT predictor with branch resolve, flush and stats
// Revision 1.0
// ==========================================================================
`default_nettype none

module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_en_i,
  input  logic [PC_W-1:0]  if_pc_i,
  output logic             pred_taken_o,
  input  logic             branch_i,
  input  logic [PC_W-1:0]  ex_pc_i,
  input  logic [2:0]       ex_func3_i,
  input  logic             zeroflag_i,
  input  logic             cf_i,
  input  logic             sf_i,
  input  logic             vf_i,
  input  logic             ex_pred_taken_i,
  input  logic [PC_W-1:0]  ex_target_i,
  input  logic [PC_W-1:0]  ex_pc_plus4_i,
  output logic             branch_taken_o,
  output logic             flush_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  input  logic             stat_clr_i,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mis_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       bht_q [ENTRIES];
  logic [1:0]       bht_upd_d;
  logic             flush_q, flush_d;
  logic [PC_W-1:0]  redirect_q, redirect_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic             w_cond;
  logic             w_legal;
  logic             w_valid;
  logic             w_mispredict;
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_unused_pc_bits;

  assign w_if_idx = if_pc_i[IDX_W+1:2];
  assign w_ex_idx = ex_pc_i[IDX_W+1:2];
  assign w_unused_pc_bits = ^{if_pc_i[PC_W-1:IDX_W+2], if_pc_i[1:0],
                              ex_pc_i[PC_W-1:IDX_W+2], ex_pc_i[1:0]};

  // cf is "no borrow", so unsigned less-than is ~cf
  always_comb begin
    w_cond  = 1'b0;
    w_legal = 1'b1;
    case (ex_func3_i)
      BR_BEQ:  w_cond = zeroflag_i;
      BR_BNE:  w_cond = ~zeroflag_i;
      BR_BLT:  w_cond = (sf_i != vf_i);
      BR_BGE:  w_cond = (sf_i == vf_i);
      BR_BLTU: w_cond = ~cf_i;
      BR_BGEU: w_cond = cf_i;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_valid        = branch_i & w_legal;
  assign branch_taken_o = w_valid & w_cond;
  assign w_mispredict   = w_valid & (branch_taken_o != ex_pred_taken_i);

  // Lookup reads the registered table directly: no bypass of a same-cycle update
  assign pred_taken_o = pred_en_i & bht_q[w_if_idx][1];

  always_comb begin
    bht_upd_d = bht_q[w_ex_idx];
    if (branch_taken_o) begin
      if (bht_q[w_ex_idx] != 2'b11) bht_upd_d = bht_q[w_ex_idx] + 2'b01;
    end else begin
      if (bht_q[w_ex_idx] != 2'b00) bht_upd_d = bht_q[w_ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (w_valid) begin
      bht_q[w_ex_idx] <= bht_upd_d;
    end
  end

  always_comb begin
    flush_d    = w_mispredict;
    redirect_d = redirect_q;
    if (w_mispredict) redirect_d = branch_taken_o ? ex_target_i : ex_pc_plus4_i;

    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (stat_clr_i) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else begin
      if (w_valid && br_cnt_q != CNT_MAX)      br_cnt_d  = br_cnt_q + CNT_ONE;
      if (w_mispredict && mis_cnt_q != CNT_MAX) mis_cnt_d = mis_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      br_cnt_q   <= '0;
      mis_cnt_q  <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      br_cnt_q   <= br_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  assign flush_o       = flush_q;
  assign redirect_pc_o = redirect_q;
  assign br_count_o    = br_cnt_q;
  assign mis_count_o   = mis_cnt_q;

endmodule

`default_nettype wire

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL provide parameter ENTRIES, default 16, number of branch-history-table (BHT) entries; power of two, 4..1024.
REQ-002 SHALL provide parameter PC_W, default 32, width of all PC and target buses.
REQ-003 SHALL provide parameter CNT_W, default 32, width of the statistics counters.
REQ-004 SHALL derive IDX_W = clog2(ENTRIES); table index = pc[IDX_W+1:2].
REQ-005 clk  in  1  single clock; all state on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 pred_en  in  1  1 = dynamic prediction; 0 = static not-taken.
REQ-008 if_pc  in  PC_W  fetch-stage PC for lookup.
REQ-009 pred_taken  out  1  combinational prediction for if_pc.
REQ-010 branch  in  1  resolve-stage instruction is a conditional branch.
REQ-011 ex_pc  in  PC_W  PC of the resolving branch.
REQ-012 ex_func3  in  3  branch func3 (`BR_* encodings).
REQ-013 zeroflag, cf, sf, vf  in  1 each  ALU flags of rs1-rs2; cf=1 means no borrow.
REQ-014 ex_pred_taken  in  1  prediction carried with the branch down the pipe.
REQ-015 ex_target  in  PC_W  computed branch target.
REQ-016 ex_pc_plus4  in  PC_W  fall-through PC.
REQ-017 branch_taken  out  1  combinational resolved outcome.
REQ-018 flush  out  1  registered one-cycle mispredict pulse.
REQ-019 redirect_pc  out  PC_W  registered correct PC, valid when flush=1.
REQ-020 stat_clr  in  1  synchronous clear of statistics counters.
REQ-021 br_count, mis_count  out  CNT_W each  resolved-branch and mispredict counters.

Function
REQ-022 Outcome: BEQ zeroflag; BNE ~zeroflag; BLT sf!=vf; BGE sf==vf; BLTU ~cf; BGEU cf; all gated by branch.
REQ-023 func3 010/011 with branch=1 SHALL be a non-branch: branch_taken=0, no BHT update, no flush, no stat increment.
REQ-024 BHT: ENTRIES x 2-bit saturating counters; pred_taken = pred_en & BHT[if_pc idx][1].
REQ-025 Valid resolve (branch=1, legal func3): taken increments entry (saturate at 3), not-taken decrements (saturate at 0), written at clock edge; update occurs regardless of pred_en.
REQ-026 Same-cycle lookup and update of same index: lookup returns pre-update value (no bypass).
REQ-027 mispredict = valid resolve & (branch_taken != ex_pred_taken); next edge flush=1, redirect_pc = branch_taken ? ex_target : ex_pc_plus4.
REQ-028 flush SHALL be 1 for exactly one cycle per mispredict; back-to-back mispredicts give consecutive flush cycles, each with its own redirect_pc.
REQ-029 redirect_pc SHALL hold its last value when flush=0.
REQ-030 br_count increments per valid resolve; mis_count per mispredict; both saturate at all-ones.
REQ-031 stat_clr has priority over same-cycle increment: counters become 0.
REQ-032 Latency: pred_taken and branch_taken 0 cycles; flush/redirect_pc/BHT/counters 1 cycle.

Reset
REQ-033 rst_n low SHALL asynchronously set every BHT entry to 2'b01 (weakly not-taken), flush=0, redirect_pc=0, br_count=0, mis_count=0.
REQ-034 Reset asserted mid-operation SHALL abort any pending flush; first edge after release performs normal operation.

Verification
REQ-035 Reset, then if_pc=0x40 with pred_en=1 -> pred_taken=0; all outputs 0.
REQ-036 Two BEQ resolves at ex_pc=0x40 with zeroflag=1, ex_pred_taken=0, ex_target=0x80 -> flush pulses each cycle with redirect_pc=0x80; entry=3; pred_taken for 0x40 =1; br_count=2, mis_count=2.
REQ-037 BLTU cf=0, ex_pred_taken=1 -> no flush; BGEU cf=0, ex_pred_taken=1, ex_pc_plus4=0x104 -> flush=1, redirect_pc=0x104.
REQ-038 ENTRIES=16: train 0x40 taken, then lookup 0x80 (same index) -> pred_taken=1 (aliasing); pred_en=0 -> pred_taken=0.
REQ-039 func3=010 with branch=1 -> branch_taken=0, no flush, counters unchanged; stat_clr with concurrent resolve -> counters 0.
REQ-040 CNT_W=4: 16 resolves -> br_count=15 (saturated); assert rst_n low mid-sequence -> all state reset immediately, without a clock edge.
